serial_addsub_decoder: RTL and testbench

Parametrised bit-serial adder/subtractor built around a decoder-based cell: one 3-to-8 minterm decoder per cycle produces the sum/difference bit and the carry/borrow. Operands are captured on a start pulse and processed LSB-first, one bit per clock, over WIDTH cycles. A one-cycle done pulse marks the registered result. It is the sequential, width-generic, add/sub-selectable successor to the single-bit full adder/subtractor cells, for area-constrained datapaths that can tolerate WIDTH-cycle latency.

---
 rtl/serial_addsub_decoder.sv | 110 +++++++++++
 tb/tb_serial_addsub_decoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_decoder.sv
// Bit-serial adder/subtractor. Each clock, a 3-to-8 minterm decoder on
// {A lsb, B lsb, carry/borrow} produces one result bit and the next carry
// (add) or borrow (sub). Operands are processed LSB-first over WIDTH cycles.
module serial_addsub_decoder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             mode_q;
    logic             a_msb;
    logic             b_msb;

    logic [2:0]       dec_idx_c;
    logic [7:0]       dec_c;
    logic             sum_c;
    logic             carry_nxt_c;
    logic [WIDTH-1:0] acc_nxt_c;
    logic             ovf_nxt_c;

    // Decoder cell: one-hot minterms drive sum, carry/borrow and signed overflow.
    always_comb begin
        dec_idx_c   = {a_sh[0], b_sh[0], carry};
        dec_c       = 8'b0000_0001 << dec_idx_c;
        sum_c       = dec_c[1] | dec_c[2] | dec_c[4] | dec_c[7];
        carry_nxt_c = mode_q ? (dec_c[1] | dec_c[2] | dec_c[3] | dec_c[7])
                             : (dec_c[3] | dec_c[5] | dec_c[6] | dec_c[7]);
        acc_nxt_c   = {sum_c, acc[WIDTH-1:1]};
        ovf_nxt_c   = (mode_q ? (a_msb != b_msb) : (a_msb == b_msb)) && (sum_c != a_msb);
    end

    // Control FSM with datapath shift registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            mode_q   <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        mode_q <= mode;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        acc    <= '0;
                        carry  <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    acc   <= acc_nxt_c;
                    carry <= carry_nxt_c;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        result   <= acc_nxt_c;
                        cout     <= carry_nxt_c;
                        overflow <= ovf_nxt_c;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_decoder.sv
// Bench for serial_addsub_decoder: four instances (WIDTH 8, 4, 2, 16) share
// clock, reset and operand buses; one is selected at a time. A queue of
// expected completions, filled from an arithmetic model or literal values,
// is checked by a single negedge monitor.
module tb_serial_addsub_decoder;

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        o;
        int          start_edge;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [15:0] a_bus;
    logic [15:0] b_bus;
    int          sel;
    int          cyc = 0;

    int vectors = 0;
    int miscompares = 0;
    exp_t exp_q[$];

    logic [3:0]  busy_w;
    logic [3:0]  done_w;
    logic [3:0]  cout_w;
    logic [3:0]  ovf_w;
    logic [7:0]  r8;
    logic [3:0]  r4;
    logic [1:0]  r2;
    logic [15:0] r16;

    logic        busy_s;
    logic        done_s;
    logic        cout_s;
    logic        ovf_s;
    logic [15:0] res_s;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_addsub_decoder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 0), .mode(mode),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .busy(busy_w[0]), .done(done_w[0]),
        .result(r8), .cout(cout_w[0]), .overflow(ovf_w[0]));
    serial_addsub_decoder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 1), .mode(mode),
        .a(a_bus[3:0]), .b(b_bus[3:0]), .busy(busy_w[1]), .done(done_w[1]),
        .result(r4), .cout(cout_w[1]), .overflow(ovf_w[1]));
    serial_addsub_decoder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2), .mode(mode),
        .a(a_bus[1:0]), .b(b_bus[1:0]), .busy(busy_w[2]), .done(done_w[2]),
        .result(r2), .cout(cout_w[2]), .overflow(ovf_w[2]));
    serial_addsub_decoder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 3), .mode(mode),
        .a(a_bus), .b(b_bus), .busy(busy_w[3]), .done(done_w[3]),
        .result(r16), .cout(cout_w[3]), .overflow(ovf_w[3]));

    // Route the selected instance to a common set of observation signals.
    always_comb begin
        busy_s = busy_w[sel];
        done_s = done_w[sel];
        cout_s = cout_w[sel];
        ovf_s  = ovf_w[sel];
        case (sel)
            0:       res_s = 16'(r8);
            1:       res_s = 16'(r4);
            2:       res_s = 16'(r2);
            default: res_s = r16;
        endcase
    end

    function automatic int width_of(input int s);
        case (s)
            0:       return 8;
            1:       return 4;
            2:       return 2;
            default: return 16;
        endcase
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                   input logic m);
        exp_t   e;
        longint mask = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ua   = longint'(av) & mask;
        longint ub   = longint'(bv) & mask;
        longint sa   = (ua >= half) ? ua - (mask + 1) : ua;
        longint sb   = (ub >= half) ? ub - (mask + 1) : ub;
        longint r    = m ? ua - ub : ua + ub;
        longint s    = m ? sa - sb : sa + sb;
        e.res = 16'(r & mask);
        e.c   = m ? (ua < ub) : ((r >> w) != 0);
        e.o   = (s < -half) || (s >= half);
        e.start_edge = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Called at a negedge: drive one start pulse and queue its expectation.
    task automatic launch(input int s, input logic [15:0] av, input logic [15:0] bv,
                          input logic m, input exp_t e);
        sel   = s;
        a_bus = av;
        b_bus = bv;
        mode  = m;
        start = 1'b1;
        e.start_edge = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a_bus = 16'($urandom);
        b_bus = 16'($urandom);
        mode  = 1'($urandom);
    endtask

    task automatic launch_model(input int s, input logic [15:0] av, input logic [15:0] bv,
                                input logic m);
        launch(s, av, bv, m, model(width_of(s), av, bv, m));
    endtask

    task automatic launch_lit(input int s, input logic [15:0] av, input logic [15:0] bv,
                              input logic m, input logic [15:0] r, input logic c, input logic o);
        exp_t e;
        e.res = r;
        e.c = c;
        e.o = o;
        e.start_edge = 0;
        launch(s, av, bv, m, e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL done_timeout: %0d completions still outstanding", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: reset values, done/busy exclusion, completions, output hold.
    initial begin
        logic [17:0] prev;
        int          prev_sel = -1;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_outputs", {busy_s, done_s, res_s, cout_s, ovf_s}, 32'h0);
                prev = '0;
                prev_sel = sel;
            end else begin
                if (busy_s && done_s) chk("done_with_busy", 32'(busy_s && done_s), 32'h0);
                if (done_s) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_done", 32'(done_s), 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", 32'(res_s), 32'(e.res));
                        chk("cout", 32'(cout_s), 32'(e.c));
                        chk("overflow", 32'(ovf_s), 32'(e.o));
                        chk("latency", 32'(cyc - e.start_edge), 32'(width_of(sel)));
                    end
                end else if (sel == prev_sel) begin
                    chk("hold_outputs", 32'({res_s, cout_s, ovf_s}), 32'(prev));
                end
                prev = {res_s, cout_s, ovf_s};
                prev_sel = sel;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        a_bus = '0;
        b_bus = '0;
        sel   = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed WIDTH=8 vectors with hand-computed expectations.
        launch_lit(0, 16'h5A, 16'h3C, 1'b0, 16'h96, 1'b0, 1'b1); wait_idle();
        launch_lit(0, 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1, 1'b0); wait_idle();
        launch_lit(0, 16'h10, 16'h20, 1'b1, 16'hF0, 1'b1, 1'b0); wait_idle();
        launch_lit(0, 16'h80, 16'h01, 1'b1, 16'h7F, 1'b0, 1'b1); wait_idle();
        launch_lit(0, 16'h00, 16'h00, 1'b1, 16'h00, 1'b0, 1'b0); wait_idle();

        // Inputs and start toggled mid-run must not disturb the operation.
        launch_lit(0, 16'h5A, 16'h3C, 1'b0, 16'h96, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        a_bus = 16'hFF; b_bus = 16'hFF; mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);

        // Back-to-back: second start during the done cycle.
        launch_lit(0, 16'h12, 16'h34, 1'b0, 16'h46, 1'b0, 1'b0);
        begin
            int n = 0;
            while (!done_s && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_done_seen", 32'(done_s), 32'h1);
        end
        launch_lit(0, 16'h7F, 16'h01, 1'b0, 16'h80, 1'b0, 1'b1);
        wait_idle();

        // Asynchronous reset mid-operation, then a fresh operation.
        launch_model(0, 16'h33, 16'h44, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {busy_s, done_s, res_s, cout_s, ovf_s}, 32'h0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        launch_lit(0, 16'hC8, 16'h64, 1'b1, 16'h64, 1'b0, 1'b1); wait_idle();

        // Exhaustive WIDTH=4.
        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++) begin
                    launch_model(1, 16'(x), 16'(y), 1'(m));
                    wait_idle();
                end

        // Random sweeps at WIDTH 2, 16 and 8.
        for (int s = 0; s < 4; s++) begin
            if (s == 1) continue;
            for (int i = 0; i < 60; i++) begin
                launch_model(s, 16'($urandom), 16'($urandom), 1'($urandom));
                wait_idle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
